// File: rtl/sram_burst_reader.sv
// Read-side burst engine for the 8K x 32b scratch SRAM.
// Issues one read per cycle from a (base, len) command, captures the 1-cycle-latency read
// data into a 2-entry skid FIFO and presents it on a valid/ready stream.
module sram_burst_reader #(
  parameter int unsigned AW = 13,
  parameter int unsigned DW = 32,
  parameter int unsigned LW = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          sram_ren,
  output logic [AW-1:0] sram_raddr,
  input  logic [DW-1:0] sram_rdata,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  input  logic          m_ready
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] remaining_q, remaining_d;

  // Read issued last cycle; its data is on sram_rdata this cycle.
  logic          inflight_q;
  logic          inflight_last_q;

  logic [DW-1:0] fifo_data_q [2];
  logic [1:0]    fifo_last_q;
  logic          rd_ptr_q, wr_ptr_q;
  logic [1:0]    count_q, count_d;

  logic          push, pop;
  logic [1:0]    occupancy;

  assign push      = inflight_q;
  assign pop       = m_valid && m_ready;
  // Words already owned by the FIFO plus the one still coming back from the SRAM.
  assign occupancy = count_q + {1'b0, inflight_q};

  assign busy       = (state_q == StRun) || (state_q == StDrain);
  assign done       = (state_q == StDone);
  assign sram_raddr = addr_q;
  assign m_valid    = (count_q != 2'd0);
  assign m_data     = m_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign m_last     = m_valid && fifo_last_q[rd_ptr_q];

  // Next-state, read issue and address/length bookkeeping.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    sram_ren    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d      = base_addr;
          remaining_d = len;
          state_d     = (len == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        // A slot is free now, or one frees up this cycle through a pop.
        sram_ren = (occupancy < 2'd2) || ((occupancy == 2'd2) && pop);
        if (sram_ren) begin
          addr_d      = addr_q + AW'(1);
          remaining_d = remaining_q - LW'(1);
          if (remaining_q == LW'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Leave as the last word pops so done follows the final pop by one cycle.
        if (!inflight_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop))) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FIFO occupancy update; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Control state, counters and in-flight tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= sram_ren;
      inflight_last_q <= sram_ren && (remaining_q == LW'(1));
    end
  end

  // Skid FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
      end
      fifo_last_q <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= sram_rdata;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_sram_burst_reader.sv
// Bench for sram_burst_reader: cycle-exact vector table for two short bursts, then
// directed sequences for backpressure, random ready, zero length, start-while-busy
// and mid-burst reset. SRAM model returns the word address as data.
module tb_sram_burst_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [12:0] base_addr;
  logic [13:0] len;
  logic        busy;
  logic        done;
  logic        sram_ren;
  logic [12:0] sram_raddr;
  logic [31:0] sram_rdata;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_last;
  logic        m_ready;

  int checks;
  int failures;

  sram_burst_reader #(.AW(13), .DW(32), .LW(14)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .sram_ren   (sram_ren),
    .sram_raddr (sram_raddr),
    .sram_rdata (sram_rdata),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_ready    (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read SRAM: mem[a] = a, data one cycle after the enable.
  initial sram_rdata = 32'h0;
  always @(posedge clk) begin
    if (sram_ren) sram_rdata <= {19'b0, sram_raddr};
  end

  // Stream monitor: collects popped words and models FIFO occupancy from the ports.
  logic [31:0] got_data[$];
  bit          got_last[$];
  int          ren_cnt;
  int          cnt_m;
  int          max_occ;
  int          model_err;
  bit          inf_m;

  initial begin
    cnt_m = 0;
    inf_m = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt_m = 0;
        inf_m = 0;
      end else begin
        if (m_valid !== (cnt_m != 0)) model_err++;
        if (m_valid && m_ready) begin
          got_data.push_back(m_data);
          got_last.push_back(m_last);
        end
        if (sram_ren) ren_cnt++;
        cnt_m = cnt_m + int'(inf_m) - int'(m_valid && m_ready);
        inf_m = sram_ren;
        if (cnt_m > max_occ) max_occ = cnt_m;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    got_data.delete();
    got_last.delete();
    ren_cnt   = 0;
    max_occ   = 0;
    model_err = 0;
  endtask

  task automatic start_burst(input logic [12:0] b, input logic [13:0] l);
    base_addr = b;
    len       = l;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic run_until_done(input int max_cycles, input bit rand_ready, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < max_cycles && !seen; c++) begin
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (done) seen = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic check_words(input string name, input logic [12:0] b, input int n);
    logic [12:0] a;
    check({name, "_count"}, 32'(got_data.size()), 32'(n));
    for (int i = 0; i < n && i < got_data.size(); i++) begin
      a = b + 13'(i);
      check($sformatf("%s_data%0d", name, i), got_data[i], {19'b0, a});
      check($sformatf("%s_last%0d", name, i), 32'(got_last[i]), 32'(i == n - 1));
    end
  endtask

  task automatic check_stream_health(input string name);
    check({name, "_fifo_le2"}, 32'(max_occ <= 2), 32'd1);
    check({name, "_valid_model"}, 32'(model_err), 32'd0);
  endtask

  typedef struct {
    bit          st;
    logic [12:0] base;
    logic [13:0] len;
    bit          rdy;
    bit          busy;
    bit          done;
    bit          ren;
    logic [12:0] raddr;
    bit          valid;
    logic [31:0] data;
    bit          last;
  } vec_t;

  vec_t tbl[18];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    int bad;

    checks    = 0;
    failures  = 0;
    // Rows: start cycle, then one row per cycle (st base len rdy | busy done ren raddr valid data last)
    tbl[0]  = '{1, 13'h0010, 14'd4, 1, 0, 0, 0, 13'h0000, 0, 32'h0000, 0};
    tbl[1]  = '{0, 13'h0000, 14'd0, 1, 1, 0, 1, 13'h0010, 0, 32'h0000, 0};
    tbl[2]  = '{0, 13'h0000, 14'd0, 1, 1, 0, 1, 13'h0011, 0, 32'h0000, 0};
    tbl[3]  = '{0, 13'h0000, 14'd0, 1, 1, 0, 1, 13'h0012, 1, 32'h0010, 0};
    tbl[4]  = '{0, 13'h0000, 14'd0, 1, 1, 0, 1, 13'h0013, 1, 32'h0011, 0};
    tbl[5]  = '{0, 13'h0000, 14'd0, 1, 1, 0, 0, 13'h0000, 1, 32'h0012, 0};
    tbl[6]  = '{0, 13'h0000, 14'd0, 1, 1, 0, 0, 13'h0000, 1, 32'h0013, 1};
    tbl[7]  = '{0, 13'h0000, 14'd0, 1, 0, 1, 0, 13'h0000, 0, 32'h0000, 0};
    tbl[8]  = '{0, 13'h0000, 14'd0, 1, 0, 0, 0, 13'h0000, 0, 32'h0000, 0};
    // Address wrap 0x1FFE -> 0x0001.
    tbl[9]  = '{1, 13'h1FFE, 14'd4, 1, 0, 0, 0, 13'h0000, 0, 32'h0000, 0};
    tbl[10] = '{0, 13'h0000, 14'd0, 1, 1, 0, 1, 13'h1FFE, 0, 32'h0000, 0};
    tbl[11] = '{0, 13'h0000, 14'd0, 1, 1, 0, 1, 13'h1FFF, 0, 32'h0000, 0};
    tbl[12] = '{0, 13'h0000, 14'd0, 1, 1, 0, 1, 13'h0000, 1, 32'h1FFE, 0};
    tbl[13] = '{0, 13'h0000, 14'd0, 1, 1, 0, 1, 13'h0001, 1, 32'h1FFF, 0};
    tbl[14] = '{0, 13'h0000, 14'd0, 1, 1, 0, 0, 13'h0000, 1, 32'h0000, 0};
    tbl[15] = '{0, 13'h0000, 14'd0, 1, 1, 0, 0, 13'h0000, 1, 32'h0001, 1};
    tbl[16] = '{0, 13'h0000, 14'd0, 1, 0, 1, 0, 13'h0000, 0, 32'h0000, 0};
    tbl[17] = '{0, 13'h0000, 14'd0, 1, 0, 0, 0, 13'h0000, 0, 32'h0000, 0};

    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    m_ready   = 1'b0;
    clear_mon();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ren", 32'(sram_ren), 32'd0);
    check("rst_raddr", 32'(sram_raddr), 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_data", m_data, 32'd0);
    check("rst_last", 32'(m_last), 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Cycle-exact table: len=4 from 0x010, then wrapping burst from 0x1FFE
    clear_mon();
    for (int i = 0; i < 18; i++) begin
      start     = tbl[i].st;
      base_addr = tbl[i].base;
      len       = tbl[i].len;
      m_ready   = tbl[i].rdy;
      @(negedge clk);
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      check($sformatf("v%0d_done", i), 32'(done), 32'(tbl[i].done));
      check($sformatf("v%0d_ren", i), 32'(sram_ren), 32'(tbl[i].ren));
      if (tbl[i].ren) check($sformatf("v%0d_raddr", i), 32'(sram_raddr), 32'(tbl[i].raddr));
      check($sformatf("v%0d_valid", i), 32'(m_valid), 32'(tbl[i].valid));
      if (tbl[i].valid) begin
        check($sformatf("v%0d_data", i), m_data, tbl[i].data);
        check($sformatf("v%0d_last", i), 32'(m_last), 32'(tbl[i].last));
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("tbl_ren_total", 32'(ren_cnt), 32'd8);
    check_stream_health("tbl");

    // Backpressure: m_ready low, only two reads may be issued and the head must hold
    clear_mon();
    m_ready = 1'b0;
    start_burst(13'h0100, 14'd4);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i >= 2 && (!m_valid || m_data !== 32'h100 || m_last)) bad++;
    end
    check("bp_ren_count", 32'(ren_cnt), 32'd2);
    check("bp_ren_low", 32'(sram_ren), 32'd0);
    check("bp_valid", 32'(m_valid), 32'd1);
    check("bp_head_stable", 32'(bad), 32'd0);
    @(posedge clk); #1;
    run_until_done(30, 1'b0, seen);
    check("bp_done_seen", 32'(seen), 32'd1);
    check_words("bp", 13'h0100, 4);
    check("bp_ren_total", 32'(ren_cnt), 32'd4);
    check_stream_health("bp");

    // Random ready over a 64-word burst
    clear_mon();
    m_ready = 1'b1;
    start_burst(13'h0800, 14'd64);
    run_until_done(1000, 1'b1, seen);
    check("rnd_done_seen", 32'(seen), 32'd1);
    check_words("rnd", 13'h0800, 64);
    check("rnd_ren_total", 32'(ren_cnt), 32'd64);
    check_stream_health("rnd");

    // Zero-length burst: done in the next cycle, no traffic
    clear_mon();
    m_ready = 1'b1;
    start_burst(13'h0030, 14'd0);
    @(negedge clk);
    check("len0_done", 32'(done), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("len0_done_once", 32'(done), 32'd0);
    check("len0_ren_total", 32'(ren_cnt), 32'd0);
    check("len0_words", 32'(got_data.size()), 32'd0);
    @(posedge clk); #1;

    // start held high while busy and through the done cycle is ignored
    clear_mon();
    start_burst(13'h0200, 14'd4);
    base_addr = 13'h0300;
    len       = 14'd8;
    start     = 1'b1;
    run_until_done(30, 1'b0, seen);
    start = 1'b0;
    check("busy_start_done_seen", 32'(seen), 32'd1);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (busy || sram_ren) bad++;
      @(posedge clk); #1;
    end
    check("busy_start_idle_after", 32'(bad), 32'd0);
    check_words("busy_start", 13'h0200, 4);
    check("busy_start_ren_total", 32'(ren_cnt), 32'd4);

    // Reset after 3 of 8 words, then a clean len=2 burst
    clear_mon();
    m_ready = 1'b1;
    start_burst(13'h0040, 14'd8);
    for (int c = 0; c < 20 && got_data.size() < 3; c++) begin
      @(posedge clk); #1;
    end
    check("mid_rst_words_before", 32'(got_data.size()), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_ren", 32'(sram_ren), 32'd0);
    check("mid_rst_raddr", 32'(sram_raddr), 32'd0);
    check("mid_rst_valid", 32'(m_valid), 32'd0);
    check("mid_rst_data", m_data, 32'd0);
    check("mid_rst_last", 32'(m_last), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    clear_mon();
    start_burst(13'h0050, 14'd2);
    run_until_done(30, 1'b0, seen);
    check("post_rst_done_seen", 32'(seen), 32'd1);
    check_words("post_rst", 13'h0050, 2);
    check("post_rst_ren_total", 32'(ren_cnt), 32'd2);
    check_stream_health("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_burst_reader.md
Name: sram_burst_reader

Overview:
- Read-side DMA front end for the 8K x 32b accelerator scratch SRAM.
- Takes a (base, length) burst command and drives the SRAM read port (read enable, address).
- Captures the SRAM's 1-cycle-latency registered read data into a 2-entry skid FIFO.
- Presents the words on a valid/ready stream to the downstream accelerator datapath: full 1-word/cycle throughput, no data loss under backpressure.

Parameters:
AW, 13, SRAM word-address width (8192 words)
DW, 32, SRAM data width
LW, 14, burst length field width (0..8192 words)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  command strobe; accepted only when busy=0
base_addr  in  AW  first word address, sampled on accepted start
len  in  LW  number of words, sampled on accepted start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when burst fully delivered
sram_ren  out  1  SRAM read enable (active high)
sram_raddr  out  AW  SRAM read address
sram_rdata  in  DW  SRAM read data, valid the cycle after sram_ren
m_valid  out  1  output word valid
m_data  out  DW  output word
m_last  out  1  marks final word of burst, qualified by m_valid
m_ready  in  1  downstream accept

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, sram_ren=0, sram_raddr=0, m_valid=0, m_data=0, m_last=0; FIFO emptied, in-flight flag cleared. Reset mid-burst discards everything; no done pulse.
- Interface is fully defined by the rules below; the block is not a thin wrapper.
- States:
  - IDLE: on start, latch addr=base_addr and remaining=len; busy=1. If len==0, go to DONE; otherwise go to RUN.
  - RUN: issue reads. After the read with remaining==1 is issued, go to DRAIN.
  - DRAIN: wait until in-flight==0 and FIFO empty, then go to DONE.
  - DONE: done=1 for exactly one cycle; busy=0 in this cycle; go to IDLE.
- start while busy=1 is ignored. start is honoured in the IDLE cycle only, so it cannot be accepted in the DONE cycle.
- Read issue rule (RUN only):
  - sram_ren=1 when (fifo_count + inflight) < 2, or when (fifo_count + inflight) == 2 and a pop occurs this cycle.
  - sram_ren and sram_raddr are combinational from state and counters.
  - On issue: addr increments by 1 modulo 2^AW (wraps 8191->0); remaining decrements by 1.
- Capture:
  - inflight is a register equal to the previous cycle's sram_ren.
  - When inflight=1, sram_rdata is pushed into the FIFO at the end of that cycle.
  - A last-flag bit travels with the word: set when the issued read had remaining==1.
- Output:
  - m_valid = (fifo_count != 0); m_data and m_last come from the FIFO head.
  - Pop on m_valid && m_ready. Push and pop in the same cycle are legal; count is unchanged.
  - The issue rule guarantees the FIFO never overflows. Overflow is a design error and the bench asserts against it.
- Latency: first m_valid is 2 cycles after the accepted start edge (issue cycle, then capture cycle).
- Throughput: with m_ready held 1, one word per cycle in steady state.
- m_data is held stable while m_valid=1 and m_ready=0.

Test Plan:
- Reset, start base=0x010, len=4, m_ready=1, SRAM preloaded mem[a]=a -> sram_raddr 0x010..0x013 on 4 consecutive cycles; m_data 0x10,0x11,0x12,0x13 on consecutive cycles; m_last only on 0x13; done pulse 1 cycle after the last pop; busy low in the done cycle.
- base=0x1FFE, len=4 -> addresses 0x1FFE,0x1FFF,0x0000,0x0001; data delivered in that order.
- len=4, m_ready held 0 -> exactly 2 reads issued then sram_ren=0; m_valid=1 and m_data stable. Release m_ready -> remaining 2 words delivered, no loss or duplication.
- Random m_ready (50%) on a len=64 burst -> all 64 words delivered in order; exactly 64 sram_ren pulses; FIFO count never exceeds 2.
- start with len=0 -> no sram_ren, no m_valid; done pulses one cycle later. start asserted while busy -> ignored, and burst 1 completes unaltered.
- rst_n asserted low mid-burst (after 3 of 8 words) -> all outputs 0 immediately. After release, a new burst len=2 runs cleanly with no stale words.
